// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified-memory arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, WAIT)
//   owner_e : which requester owns the in-flight transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int MAX_STARVE_DEF = 4;
  localparam int TIMEOUT_DEF    = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority selector: data wins over fetch unless fetch has been passed over
// MAX_STARVE times in a row, in which case fetch is forced through.
//   i_req, d_req : pending requests
//   starve_cnt   : consecutive data grants taken while fetch waited
//   grant_i/d    : one-hot (or none) winner
module mem_arb_pick #(
  parameter int MAX_STARVE = 4,
  parameter int SW         = 3
) (
  input  logic          i_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_i,
  output logic          grant_d
);

  always_comb begin
    grant_i = i_req && (!d_req || (starve_cnt == SW'(MAX_STARVE)));
    grant_d = d_req && !grant_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (i_*) and
// load/store (d_*). One transaction in flight at a time:
//   IDLE  : pick a winner, accept it (ready), latch its fields
//   ISSUE : hold m_req with latched fields until m_gnt
//   WAIT  : wait for m_rvalid, or abort after TIMEOUT idle cycles
// Ports:
//   i_req/i_addr -> i_ready, i_rvalid/i_rdata        fetch side
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_ready,
//     d_rvalid/d_rdata                               load/store side
//   m_req/m_we/m_addr/m_wdata/m_wstrb, m_gnt,
//     m_rvalid/m_rdata                               memory side
//   busy (state != IDLE), timeout_err (sticky until reset)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = MAX_STARVE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                timeout_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SW     = $clog2(MAX_STARVE + 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;

  logic                grant_i, grant_d;
  logic                resp;
  logic [DATA_W-1:0]   resp_data;

  mem_arb_pick #(
    .MAX_STARVE (MAX_STARVE),
    .SW         (SW)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    resp       = 1'b0;
    resp_data  = '0;

    case (state_q)
      IDLE: begin
        // ready is gated by reset so every output reads 0 while held in reset
        i_ready = grant_i && rst;
        d_ready = grant_d && rst;
        if (grant_i) begin
          owner_d  = OWN_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          starve_d = '0;
          state_d  = ISSUE;
        end else if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          wstrb_d = d_wstrb;
          if (i_req && (starve_q != SW'(MAX_STARVE)))
            starve_d = starve_q + SW'(1);
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (m_gnt) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // tmo_q counts WAIT cycles already spent without completion; the
        // abort fires in the cycle that finds it at TIMEOUT
        if (m_rvalid) begin
          resp      = 1'b1;
          resp_data = we_q ? '0 : m_rdata;
        end else if (tmo_q == 8'(TIMEOUT)) begin
          resp  = 1'b1;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
        if (resp) begin
          state_d = IDLE;
          if (owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = resp_data;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = resp_data;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      starve_q   <= '0;
      tmo_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign m_req       = (state_q == ISSUE);
  assign m_we        = we_q;
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign m_wstrb     = wstrb_q;
  assign busy        = (state_q != IDLE);
  assign i_rvalid    = i_rvalid_q;
  assign d_rvalid    = d_rvalid_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates one shared single-port memory between the CPU instruction-fetch path (pc/mem side) and the load/store path (data_mem side), enabling a unified-memory multi-cycle core. Each requester uses a req/ready accept handshake and a one-cycle response pulse. The memory side uses req/gnt plus a variable-latency rvalid. Data accesses have priority, with a starvation guard for fetch and a response timeout.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
MAX_STARVE, 4, consecutive data grants allowed while fetch waits before fetch is forced
TIMEOUT, 255, WAIT-state cycles without m_rvalid before abort (8-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_req  in  1  fetch request
i_addr  in  ADDR_W  fetch address
i_ready  out  1  fetch request accepted this cycle (combinational, IDLE only)
i_rvalid  out  1  one-cycle fetch response pulse
i_rdata  out  DATA_W  fetch data, valid with i_rvalid
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  byte strobes
d_ready  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle data response pulse (loads and stores)
d_rdata  out  DATA_W  load data; 0 for stores
m_req  out  1  memory request
m_we, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields
m_gnt  in  1  memory accepted m_req
m_rvalid  in  1  memory completion (reads and writes)
m_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on any timeout

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, tmo_cnt=0. All outputs 0, including m_req and timeout_err. Any in-flight transaction is dropped and no response is issued. A late m_rvalid after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - Fetch wins if i_req and (!d_req or starve_cnt==MAX_STARVE); otherwise data wins if d_req.
  - Winner's ready=1 in the same cycle; loser's ready=0.
  - On accept: latch addr/we/wdata/wstrb/owner. Fetch forces we=0 and wstrb=0. Go to ISSUE.
- starve_cnt:
  - Data grant while i_req=1: starve_cnt+1, saturating at MAX_STARVE.
  - Fetch grant: clear to 0.
  - Otherwise: hold.
- ISSUE: m_req=1 with latched fields, held stable until m_gnt. On m_gnt go to WAIT and clear tmo_cnt. No timeout applies in ISSUE.
- WAIT: m_req=0.
  - On m_rvalid: register owner rdata (m_rdata for loads/fetch, 0 for stores), pulse owner rvalid for exactly the next cycle, go to IDLE.
  - Else tmo_cnt+1. When tmo_cnt==TIMEOUT: pulse owner rvalid with rdata=0, set timeout_err, go to IDLE.
- Latency: accept at cycle 0 → m_req at cycle 1; with m_gnt at 1 and m_rvalid at 2, owner rvalid is at cycle 3. Minimum 3 cycles per transaction.
- The response pulse and the next IDLE accept may occur in the same cycle.
- rdata outputs hold their last value between pulses.
- m_gnt outside ISSUE and m_rvalid outside WAIT are ignored.
- Requester inputs are don't-care once accepted. Requesters must hold req/fields until ready.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT), owner enum (OWN_I, OWN_D), and the default constants for MAX_STARVE and TIMEOUT.
- One natural sub-module, mem_arb_pick: combinational priority/starvation selector taking i_req, d_req and starve_cnt, returning grant_i and grant_d.
- FSM, latches and counters stay in mem_arbiter.

Test Plan:
- Reset mid-WAIT: assert rst=0 while in WAIT → all outputs 0 immediately. After release, a stale m_rvalid produces no i_/d_rvalid; busy=0.
- Single load: d_req, d_addr=0x40; m_gnt at cycle 1; m_rvalid with m_rdata=0xDEADBEEF at cycle 2 → d_rvalid=1 and d_rdata=0xDEADBEEF at cycle 3, for one cycle only.
- Store: d_we=1, d_wdata=0x12345678, d_wstrb=4'b0011, m_gnt delayed 3 cycles → m_req and fields stable for 4 cycles; d_rvalid pulses with d_rdata=0.
- Contention and starvation: i_req and d_req held high continuously → grant order is D,D,D,D,I,D,…; starve_cnt returns to 0 after the fetch grant.
- Timeout: grant given, m_rvalid never arrives → owner rvalid pulses with rdata=0 after TIMEOUT=255 WAIT cycles; timeout_err=1 and stays 1 until reset.
- Fetch only: i_req, i_addr=0x0 with m_rdata=0x00000013 → i_rvalid and i_rdata=0x13; d_ready stays 0 throughout.
